pipe_hazard_ctrl: RTL and testbench

//   Sequencer for the four pipeline buffers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: drives the IF/ID, ID/EX, EX/MEM and MEM/WB buffer
// enables and flushes plus PC hold. It handles memory stalls, load-use bubbles,
// taken-branch squashes and interrupt entry.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   RUN       | normal issue; load-use bubbles and interrupt acceptance live here
//   INT_DRAIN | front end squashed and PC held while older instructions retire
//   INT_ACK   | single-cycle acknowledge; PC released to the vector fetch
module pipe_hazard_ctrl #(
  parameter int MEM_LAT    = 2,
  parameter int INT_CYCLES = 3,
  parameter int REG_AW     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_Rsrc1,
  input  logic [REG_AW-1:0] id_Rsrc2,
  input  logic              id_use1,
  input  logic              id_use2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_Rdst,
  input  logic              mem_req,
  input  logic              branch_taken,
  input  logic              int_req,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic              pc_hold,
  output logic              int_ack
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    INT_DRAIN = 2'd1,
    INT_ACK   = 2'd2
  } state_e;

  // Counter widths never drop below one bit so MEM_LAT=1 / INT_CYCLES=1 still elaborate.
  localparam int MCW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int ICW = (INT_CYCLES > 1) ? $clog2(INT_CYCLES) : 1;
  localparam logic [MCW-1:0] MCNT_LAST = MCW'(MEM_LAT - 1);
  localparam logic [ICW-1:0] ICNT_LOAD = ICW'(INT_CYCLES - 1);

  state_e         state_q, state_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic [ICW-1:0] icnt_q, icnt_d;
  logic           int_pend_q, int_pend_d;

  logic stall_mem;
  logic load_use;
  logic int_accept;

  // With MEM_LAT=1 MCNT_LAST is 0, so the compare is never true and no stall occurs.
  assign stall_mem = mem_req && (mcnt_q < MCNT_LAST);

  assign load_use = ex_mem_read &&
                    ((id_use1 && (id_Rsrc1 == ex_Rdst)) ||
                     (id_use2 && (id_Rsrc2 == ex_Rdst)));

  assign int_accept = (state_q == RUN) && int_pend_q &&
                      !stall_mem && !branch_taken && !load_use;

  // State register plus the stall counter, drain counter and pending-interrupt flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      mcnt_q     <= '0;
      icnt_q     <= '0;
      int_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcnt_q     <= mcnt_d;
      icnt_q     <= icnt_d;
      int_pend_q <= int_pend_d;
    end
  end

  // Next-state logic; a memory stall freezes both the FSM and the drain counter
  always_comb begin
    state_d    = state_q;
    icnt_d     = icnt_q;
    mcnt_d     = stall_mem ? (mcnt_q + MCW'(1)) : '0;
    int_pend_d = int_pend_q | int_req;

    if (!stall_mem) begin
      unique case (state_q)
        RUN: begin
          if (int_accept) begin
            state_d = INT_DRAIN;
            icnt_d  = ICNT_LOAD;
          end
        end
        INT_DRAIN: begin
          // A taken branch during drain only redirects the PC; counting continues.
          if (icnt_q == '0) begin
            state_d = INT_ACK;
          end else begin
            icnt_d = icnt_q - ICW'(1);
          end
        end
        INT_ACK: begin
          state_d = RUN;
          // A request arriving in the ack cycle itself must not be lost.
          int_pend_d = int_req;
        end
        default: begin
          state_d = RUN;
        end
      endcase
    end
  end

  // Output decode: reset > memory stall > taken branch > per-state behaviour
  always_comb begin
    en_if_id    = 1'b1;
    en_id_ex    = 1'b1;
    en_ex_mem   = 1'b1;
    en_mem_wb   = 1'b1;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    pc_hold     = 1'b0;
    int_ack     = 1'b0;

    if (rst) begin
      en_if_id    = 1'b0;
      en_id_ex    = 1'b0;
      en_ex_mem   = 1'b0;
      en_mem_wb   = 1'b0;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      pc_hold     = 1'b1;
    end else if (stall_mem) begin
      // Whole pipe freezes, MEM/WB included, so the repeated WB write is harmless.
      en_if_id  = 1'b0;
      en_id_ex  = 1'b0;
      en_ex_mem = 1'b0;
      en_mem_wb = 1'b0;
      pc_hold   = 1'b1;
    end else if (branch_taken) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      int_ack     = (state_q == INT_ACK);
    end else begin
      unique case (state_q)
        RUN: begin
          if (load_use) begin
            en_if_id    = 1'b0;
            pc_hold     = 1'b1;
            flush_id_ex = 1'b1;
          end
        end
        INT_DRAIN: begin
          pc_hold     = 1'b1;
          flush_if_id = 1'b1;
        end
        INT_ACK: begin
          int_ack     = 1'b1;
          flush_if_id = 1'b1;
        end
        default: begin
          pc_hold = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a sequential vector table followed by
// hand-written reset-abort and long-stall interrupt sequences.
module tb_pipe_hazard_ctrl;

  localparam int REG_AW = 3;

  // Packed output order: {en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
  //                       flush_if_id, flush_id_ex, pc_hold, int_ack}
  localparam logic [7:0] O_DEF   = 8'hF0;
  localparam logic [7:0] O_STALL = 8'h02;
  localparam logic [7:0] O_BR    = 8'hFC;
  localparam logic [7:0] O_LU    = 8'h76;
  localparam logic [7:0] O_DRAIN = 8'hFA;
  localparam logic [7:0] O_ACK   = 8'hF9;
  localparam logic [7:0] O_BRACK = 8'hFD;
  localparam logic [7:0] O_RST   = 8'h0E;

  typedef struct {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
    logic              exrd;
    logic [REG_AW-1:0] rd;
    logic              mreq;
    logic              br;
    logic              ireq;
    logic [7:0]        exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [REG_AW-1:0] id_Rsrc1, id_Rsrc2, ex_Rdst;
  logic id_use1, id_use2, ex_mem_read, mem_req, branch_taken, int_req;

  logic a_en_if_id, a_en_id_ex, a_en_ex_mem, a_en_mem_wb;
  logic a_flush_if_id, a_flush_id_ex, a_pc_hold, a_int_ack;
  logic b_en_if_id, b_en_id_ex, b_en_ex_mem, b_en_mem_wb;
  logic b_flush_if_id, b_flush_id_ex, b_pc_hold, b_int_ack;

  logic [7:0] out_a, out_b;
  assign out_a = {a_en_if_id, a_en_id_ex, a_en_ex_mem, a_en_mem_wb,
                  a_flush_if_id, a_flush_id_ex, a_pc_hold, a_int_ack};
  assign out_b = {b_en_if_id, b_en_id_ex, b_en_ex_mem, b_en_mem_wb,
                  b_flush_if_id, b_flush_id_ex, b_pc_hold, b_int_ack};

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_LAT(2), .INT_CYCLES(3), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .id_Rsrc1(id_Rsrc1), .id_Rsrc2(id_Rsrc2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_mem_read(ex_mem_read), .ex_Rdst(ex_Rdst), .mem_req(mem_req),
    .branch_taken(branch_taken), .int_req(int_req),
    .en_if_id(a_en_if_id), .en_id_ex(a_en_id_ex), .en_ex_mem(a_en_ex_mem),
    .en_mem_wb(a_en_mem_wb), .flush_if_id(a_flush_if_id), .flush_id_ex(a_flush_id_ex),
    .pc_hold(a_pc_hold), .int_ack(a_int_ack)
  );

  pipe_hazard_ctrl #(.MEM_LAT(3), .INT_CYCLES(3), .REG_AW(REG_AW)) dut3 (
    .clk(clk), .rst(rst),
    .id_Rsrc1(id_Rsrc1), .id_Rsrc2(id_Rsrc2), .id_use1(id_use1), .id_use2(id_use2),
    .ex_mem_read(ex_mem_read), .ex_Rdst(ex_Rdst), .mem_req(mem_req),
    .branch_taken(branch_taken), .int_req(int_req),
    .en_if_id(b_en_if_id), .en_id_ex(b_en_id_ex), .en_ex_mem(b_en_ex_mem),
    .en_mem_wb(b_en_mem_wb), .flush_if_id(b_flush_if_id), .flush_id_ex(b_flush_id_ex),
    .pc_hold(b_pc_hold), .int_ack(b_int_ack)
  );

  function automatic vec_t mk(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                              input logic u1, input logic u2, input logic exrd,
                              input logic [REG_AW-1:0] rd, input logic mreq,
                              input logic br, input logic ireq, input logic [7:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.exrd = exrd;
    v.rd = rd; v.mreq = mreq; v.br = br; v.ireq = ireq; v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    id_Rsrc1 = v.rs1; id_Rsrc2 = v.rs2; id_use1 = v.u1; id_use2 = v.u2;
    ex_mem_read = v.exrd; ex_Rdst = v.rd; mem_req = v.mreq;
    branch_taken = v.br; int_req = v.ireq;
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b expected %b", nm, act, exp);
    end
  endtask

  vec_t vecs[38];
  vec_t zero_v;

  initial begin
    // load-use patterns: LU2 = rs2 match via use2, LU1 = rs1 match via use1
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_STALL);   // first mem cycle stalls
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF);     // second mem cycle released
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_STALL);   // mcnt was cleared
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF);
    vecs[6]  = mk(0, 3, 0, 1, 1, 3, 0, 0, 0, O_LU);
    vecs[7]  = mk(0, 3, 0, 0, 1, 3, 0, 0, 0, O_DEF);     // use2 low
    vecs[8]  = mk(5, 0, 1, 0, 1, 5, 0, 0, 0, O_LU);
    vecs[9]  = mk(5, 0, 1, 0, 0, 5, 0, 0, 0, O_DEF);     // not a load
    vecs[10] = mk(4, 0, 1, 0, 1, 5, 0, 0, 0, O_DEF);     // address mismatch
    vecs[11] = mk(0, 3, 0, 1, 1, 3, 0, 1, 0, O_BR);      // branch beats load-use
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR);
    vecs[13] = mk(0, 3, 0, 1, 1, 3, 1, 0, 0, O_STALL);   // stall beats load-use
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_BR);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF);     // int pulse
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);     // accepted here
    vecs[17] = mk(0, 3, 0, 1, 1, 3, 0, 0, 0, O_DRAIN);   // load-use ignored in drain
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BR);      // branch in drain
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_ACK);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    vecs[23] = mk(0, 3, 0, 1, 1, 3, 0, 0, 1, O_LU);      // int set during bubble
    vecs[24] = mk(0, 3, 0, 1, 1, 3, 0, 0, 0, O_LU);      // load-use blocks accept
    vecs[25] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_STALL);   // stall blocks accept
    vecs[26] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DEF);     // accepted here
    vecs[27] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_STALL);   // stall inside drain
    vecs[28] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_DRAIN);
    vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[30] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[31] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_ACK);     // re-request in ack cycle
    vecs[32] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);     // pend survived, accepted
    vecs[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[34] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[35] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DRAIN);
    vecs[36] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, O_BRACK);   // branch in ack cycle
    vecs[37] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);
    zero_v   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_DEF);

    // Reset state
    rst = 1'b1;
    apply(zero_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", out_a, O_RST);
    check("reset_outputs_ml3", out_b, O_RST);
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential vector table
    for (int i = 0; i < 38; i++) begin
      apply(vecs[i]);
      @(negedge clk);
      check($sformatf("vec%0d", i), out_a, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Reset abandons an interrupt in the middle of INT_DRAIN
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_DEF));
    @(negedge clk); check("rstdrain_req", out_a, O_DEF);
    @(posedge clk); #1;
    apply(zero_v);
    @(negedge clk); check("rstdrain_accept", out_a, O_DEF);
    @(posedge clk); #1;
    @(negedge clk); check("rstdrain_drain", out_a, O_DRAIN);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 check("rstdrain_async", out_a, O_RST);
    @(negedge clk); check("rstdrain_held", out_a, O_RST);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("rstdrain_after%0d", i), out_a, O_DEF);
      @(posedge clk); #1;
    end

    // MEM_LAT=3: interrupt pulse during a stall is only accepted once it releases
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, O_STALL));
    @(negedge clk); check("ml3_stall0", out_b, O_STALL);
    @(posedge clk); #1;
    apply(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_STALL));
    @(negedge clk); check("ml3_stall1", out_b, O_STALL);
    @(posedge clk); #1;
    @(negedge clk); check("ml3_release", out_b, O_DEF);
    @(posedge clk); #1;
    apply(zero_v);
    @(negedge clk); check("ml3_drain0", out_b, O_DRAIN);
    @(posedge clk); #1;
    @(negedge clk); check("ml3_drain1", out_b, O_DRAIN);
    @(posedge clk); #1;
    @(negedge clk); check("ml3_drain2", out_b, O_DRAIN);
    @(posedge clk); #1;
    @(negedge clk); check("ml3_ack", out_b, O_ACK);
    @(posedge clk); #1;
    @(negedge clk); check("ml3_run", out_b, O_DEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
